// File: rtl/instr_mem_responder.sv
// ---------------------------------------------------------------------------
// instr_mem_responder
//
// Instruction memory for the 4-bit processor. It answers fetch requests from
// the control unit with one cycle of latency, through a 2-entry response
// queue and a valid/ready handshake. A program-load port fills the array.
// Per-entry valid bits flag slots that were never programmed. The data of
// such a slot is returned as 0, with rsp_empty_o set.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   fetch_req_i       fetch request from the control unit
//   fetch_addr_i      fetch address (pc)
//   fetch_ready_o     a fetch can be accepted this cycle
//   rsp_valid_o       a response is at the queue head
//   rsp_data_o        instruction word at the queue head (0 when empty)
//   rsp_empty_o       the head response came from an unprogrammed slot
//   rsp_ready_i       the control unit consumes the head response
//   prog_we_i         write one instruction
//   prog_addr_i       program write address
//   prog_data_i       program write data
//   prog_clear_i      invalidate all entries (a same-cycle write still wins)
//   fetch_cnt_o       count of completed responses, modulo 256
// ---------------------------------------------------------------------------
module instr_mem_responder #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req_i,
  input  logic [AW-1:0] fetch_addr_i,
  output logic          fetch_ready_o,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_empty_o,
  input  logic          rsp_ready_i,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [DW-1:0] prog_data_i,
  input  logic          prog_clear_i,
  output logic [7:0]    fetch_cnt_o
);

  localparam int DEPTH = 1 << AW;

  // Instruction array and the per-entry programmed flags.
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;

  // Response queue: two slots addressed by wrapping 1-bit pointers.
  logic [DW-1:0] qdata_q [2];
  logic [1:0]    qempty_q;
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;

  logic          rst_done_q;
  logic [7:0]    cnt_q;

  logic          push, pop;
  logic          rd_vld;
  logic [DW-1:0] rd_data;

  assign fetch_ready_o = rst_done_q && (count_q != 2'd2);
  assign rsp_valid_o   = (count_q != 2'd0);
  assign rsp_data_o    = rsp_valid_o ? qdata_q[rd_ptr_q] : '0;
  assign rsp_empty_o   = rsp_valid_o ? qempty_q[rd_ptr_q] : 1'b0;
  assign fetch_cnt_o   = cnt_q;

  assign push = fetch_req_i && fetch_ready_o;
  assign pop  = rsp_valid_o && rsp_ready_i;

  // The array is read combinationally from the current register state. A
  // write or clear at the same edge therefore cannot affect this fetch:
  // the fetch sees the contents from before the write.
  assign rd_vld  = vld_q[fetch_addr_i];
  assign rd_data = rd_vld ? mem_q[fetch_addr_i] : '0;

  always_comb begin
    vld_d = vld_q;
    if (prog_clear_i) vld_d = '0;
    if (prog_we_i)    vld_d[prog_addr_i] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state: flags, pointers, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done_q <= 1'b0;
      vld_q      <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      rst_done_q <= 1'b1;
      vld_q      <= vld_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        cnt_q    <= cnt_q + 8'd1;
      end
    end
  end

  // Data storage is not reset. The vld and count registers gate its visibility.
  always_ff @(posedge clk) begin
    if (prog_we_i) mem_q[prog_addr_i] <= prog_data_i;
    if (push) begin
      qdata_q[wr_ptr_q]  <= rd_data;
      qempty_q[wr_ptr_q] <= ~rd_vld;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_req_i;
  logic [3:0] fetch_addr_i;
  logic       fetch_ready_o;
  logic       rsp_valid_o;
  logic [3:0] rsp_data_o;
  logic       rsp_empty_o;
  logic       rsp_ready_i;
  logic       prog_we_i;
  logic [3:0] prog_addr_i;
  logic [3:0] prog_data_i;
  logic       prog_clear_i;
  logic [7:0] fetch_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  instr_mem_responder #(.AW(4), .DW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req_i  (fetch_req_i),
    .fetch_addr_i (fetch_addr_i),
    .fetch_ready_o(fetch_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_empty_o  (rsp_empty_o),
    .rsp_ready_i  (rsp_ready_i),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_data_i  (prog_data_i),
    .prog_clear_i (prog_clear_i),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  // One row = one clock cycle. The inputs are driven for that cycle, and the
  // outputs are the values expected during that cycle (before its edge).
  typedef struct {
    logic       freq;
    logic [3:0] faddr;
    logic       rrdy;
    logic       we;
    logic [3:0] waddr;
    logic [3:0] wdata;
    logic       clr;
    logic       e_frdy;
    logic       e_rv;
    logic [3:0] e_rd;
    logic       e_re;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(logic freq, logic [3:0] faddr, logic rrdy,
                              logic we, logic [3:0] waddr, logic [3:0] wdata,
                              logic clr, logic e_frdy, logic e_rv,
                              logic [3:0] e_rd, logic e_re, logic [7:0] e_cnt);
    vec_t v;
    v.freq = freq; v.faddr = faddr; v.rrdy = rrdy;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.clr = clr;
    v.e_frdy = e_frdy; v.e_rv = e_rv; v.e_rd = e_rd; v.e_re = e_re;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic freq, input logic [3:0] faddr, input logic rrdy,
                       input logic we, input logic [3:0] waddr, input logic [3:0] wdata,
                       input logic clr);
    fetch_req_i  = freq;
    fetch_addr_i = faddr;
    rsp_ready_i  = rrdy;
    prog_we_i    = we;
    prog_addr_i  = waddr;
    prog_data_i  = wdata;
    prog_clear_i = clr;
  endtask

  task automatic chk_out(input string tag, input logic frdy, input logic rv,
                         input logic [3:0] rd, input logic re, input logic [7:0] cnt);
    chk({tag, "_frdy"}, {7'd0, fetch_ready_o}, {7'd0, frdy});
    chk({tag, "_rv"},   {7'd0, rsp_valid_o},   {7'd0, rv});
    chk({tag, "_rd"},   {4'd0, rsp_data_o},    {4'd0, rd});
    chk({tag, "_re"},   {7'd0, rsp_empty_o},   {7'd0, re});
    chk({tag, "_cnt"},  fetch_cnt_o,           cnt);
  endtask

  initial begin
    //                freq addr rrdy we waddr  wdata    clr | frdy rv rd       re cnt
    vecs[0]  = mk(0, 4'd0, 0, 1, 4'd3, 4'b1011, 0,  1, 0, 4'b0000, 0, 8'd0);
    vecs[1]  = mk(1, 4'd3, 1, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd0);
    vecs[2]  = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b1011, 0, 8'd0);
    vecs[3]  = mk(1, 4'd7, 1, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd1);
    vecs[4]  = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b0000, 1, 8'd1);
    vecs[5]  = mk(0, 4'd0, 0, 0, 4'd0, 4'b0000, 1,  1, 0, 4'b0000, 0, 8'd2);
    vecs[6]  = mk(1, 4'd3, 1, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd2);
    vecs[7]  = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b0000, 1, 8'd2);
    vecs[8]  = mk(0, 4'd0, 0, 1, 4'd1, 4'b0100, 0,  1, 0, 4'b0000, 0, 8'd3);
    vecs[9]  = mk(0, 4'd0, 0, 1, 4'd2, 4'b1001, 0,  1, 0, 4'b0000, 0, 8'd3);
    vecs[10] = mk(0, 4'd0, 0, 1, 4'd3, 4'b1110, 0,  1, 0, 4'b0000, 0, 8'd3);
    // Backpressure: 1 and 2 are accepted, 3 waits until a pop frees a slot.
    vecs[11] = mk(1, 4'd1, 0, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd3);
    vecs[12] = mk(1, 4'd2, 0, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b0100, 0, 8'd3);
    vecs[13] = mk(1, 4'd3, 0, 0, 4'd0, 4'b0000, 0,  0, 1, 4'b0100, 0, 8'd3);
    vecs[14] = mk(1, 4'd3, 1, 0, 4'd0, 4'b0000, 0,  0, 1, 4'b0100, 0, 8'd3);
    vecs[15] = mk(1, 4'd3, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b1001, 0, 8'd4);
    vecs[16] = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b1110, 0, 8'd5);
    vecs[17] = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd6);
    // Read-before-write collision on addr 5.
    vecs[18] = mk(0, 4'd0, 1, 1, 4'd5, 4'b0001, 0,  1, 0, 4'b0000, 0, 8'd6);
    vecs[19] = mk(1, 4'd5, 1, 1, 4'd5, 4'b0110, 0,  1, 0, 4'b0000, 0, 8'd6);
    vecs[20] = mk(1, 4'd5, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b0001, 0, 8'd6);
    vecs[21] = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b0110, 0, 8'd7);
    vecs[22] = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd8);
    // Clear and write in the same cycle: the written entry stays valid.
    vecs[23] = mk(0, 4'd0, 1, 1, 4'd9, 4'b1010, 1,  1, 0, 4'b0000, 0, 8'd8);
    vecs[24] = mk(1, 4'd9, 1, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd8);
    vecs[25] = mk(1, 4'd5, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b1010, 0, 8'd8);
    vecs[26] = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 1, 4'b0000, 1, 8'd9);
    vecs[27] = mk(0, 4'd0, 1, 0, 4'd0, 4'b0000, 0,  1, 0, 4'b0000, 0, 8'd10);

    // Reset and idle.
    rst_n = 1'b0;
    drive(0, 4'd0, 0, 0, 4'd0, 4'd0, 0);
    repeat (3) @(negedge clk);
    #1 chk_out("reset", 0, 0, 4'd0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_frdy", {7'd0, fetch_ready_o}, 8'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].freq, vecs[i].faddr, vecs[i].rrdy, vecs[i].we,
            vecs[i].waddr, vecs[i].wdata, vecs[i].clr);
      #1 chk_out($sformatf("v%0d", i), vecs[i].e_frdy, vecs[i].e_rv,
                 vecs[i].e_rd, vecs[i].e_re, vecs[i].e_cnt);
    end

    // Sustained fetches of addr 9 until 256 responses have completed.
    // Response count so far is 10, so 246 more pops are needed.
    for (int i = 0; i < 246; i++) begin
      @(negedge clk);
      drive(1, 4'd9, 1, 0, 4'd0, 4'd0, 0);
      #1;
      if (i == 0 || i == 123 || i == 245) begin
        chk($sformatf("stream%0d_frdy", i), {7'd0, fetch_ready_o}, 8'd1);
        chk($sformatf("stream%0d_rv", i), {7'd0, rsp_valid_o}, (i == 0) ? 8'd0 : 8'd1);
        chk($sformatf("stream%0d_cnt", i), fetch_cnt_o, 8'(10 + ((i == 0) ? 0 : i - 1)));
      end
    end
    @(negedge clk);
    drive(0, 4'd0, 1, 0, 4'd0, 4'd0, 0);
    #1 chk_out("wrap_pre", 1, 1, 4'b1010, 0, 8'd255);
    @(negedge clk);
    #1 chk_out("wrap", 1, 0, 4'd0, 0, 8'd0);

    // Queue two responses under backpressure, then reset mid-operation.
    @(negedge clk);
    drive(1, 4'd9, 0, 0, 4'd0, 4'd0, 0);
    @(negedge clk);
    drive(1, 4'd9, 0, 0, 4'd0, 4'd0, 0);
    @(negedge clk);
    drive(0, 4'd0, 0, 0, 4'd0, 4'd0, 0);
    #1 chk_out("full", 0, 1, 4'b1010, 0, 8'd0);
    rst_n = 1'b0;
    #1 chk_out("midrst", 0, 0, 4'd0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_out("midrst_rel", 0, 0, 4'd0, 0, 8'd0);
    // Addr 9 was programmed before the reset; the reset must have cleared its flag.
    @(negedge clk);
    drive(1, 4'd9, 1, 0, 4'd0, 4'd0, 0);
    #1 chk_out("post_rst", 1, 0, 4'd0, 0, 8'd0);
    @(negedge clk);
    drive(0, 4'd0, 1, 0, 4'd0, 4'd0, 0);
    #1 chk_out("post_rst_rsp", 1, 1, 4'd0, 1, 8'd0);
    @(negedge clk);
    #1 chk_out("post_rst_idle", 1, 0, 4'd0, 0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-memory responder for the 4-bit processor. It serves the control unit's fetch requests (address in, 4-bit instruction out) over a valid/ready handshake with one-cycle latency and a 2-entry response queue. A program-load write port fills the array, and per-entry valid bits let the fetcher tell an unprogrammed slot from a real instruction. It sits between the control unit's fetch stage and the program loader.

## Interface
- AW, 4, address width; DEPTH = 2**AW entries.
- DW, 4, instruction width: register bit, operation bit, 2-bit number.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_req_i  input  1  control unit presents a fetch.
- fetch_addr_i  input  AW  fetch address (pc).
- fetch_ready_o  output  1  responder can accept a fetch this cycle.
- rsp_valid_o  output  1  response at queue head.
- rsp_data_o  output  DW  instruction word.
- rsp_empty_o  output  1  addressed entry was never programmed (data forced to 0).
- rsp_ready_i  input  1  control unit consumes the head response.
- prog_we_i  input  1  write one instruction.
- prog_addr_i  input  AW  write address.
- prog_data_i  input  DW  write data.
- prog_clear_i  input  1  invalidate all entries.
- fetch_cnt_o  output  8  count of completed responses, wraps 255 -> 0.

## Operation
- Storage: mem[DEPTH] of DW bits, not reset. vld[DEPTH] is reset to 0.
- Fetch accept: the request is accepted when fetch_req_i and fetch_ready_o are both 1. The array is read at fetch_addr_i that cycle, and {vld ? mem : 0, !vld} is pushed into the response queue at the clock edge.
- Response queue: 2-entry FIFO with a count of 0..2. The head drives rsp_data_o/rsp_empty_o, and rsp_valid_o = (count != 0). A pop occurs when rsp_valid_o and rsp_ready_i are both 1.
- fetch_ready_o = rst_done and (count < 2). It does not depend combinationally on rsp_ready_i. A push and a pop in the same cycle leave the count unchanged.
- rst_done is a flop: 0 in reset, 1 from the first clock edge after rst_n deasserts.
- With the queue empty, rsp_data_o = 0 and rsp_empty_o = 0.
- Program write: on prog_we_i, mem[prog_addr_i] <= prog_data_i and vld[prog_addr_i] <= 1. Writes are allowed every cycle and are independent of the fetch handshake.
- Clear: prog_clear_i sets all vld to 0 in one cycle; mem is untouched. If prog_we_i occurs in the same cycle, the written entry ends with vld = 1 (write wins).
- Read/write collision: a fetch accepted in the same cycle as a write or clear to its address returns the pre-write contents and valid bit (read-before-write).
- fetch_cnt_o increments on each pop and wraps modulo 256.
- Addresses are always in range (DEPTH = 2**AW); there is no error path.

## Timing
- Reset values: fetch_ready_o 0, rsp_valid_o 0, rsp_data_o 0, rsp_empty_o 0, fetch_cnt_o 0, queue count 0, all vld 0.
- Latency: a fetch accepted at edge N gives rsp_valid_o = 1 in the cycle after edge N, with data stable until popped.
- Throughput: with rsp_ready_i held at 1, one fetch per cycle is sustained.
- Backpressure: with rsp_ready_i at 0, two fetches are accepted, then fetch_ready_o drops. It returns to 1 the cycle after a pop.
- Reset mid-operation: the queue is flushed, in-flight responses are lost, vld is cleared, and fetch_ready_o is 0 until the first edge after release.
- A program write at edge N is visible to a fetch accepted at edge N+1 or later.

## Test plan
- Reset then idle: all outputs match the reset values. fetch_ready_o rises 1 cycle after rst_n release.
- Program addr 3 = 4'b1011, then fetch addr 3 with rsp_ready_i at 1 -> the next cycle gives rsp_valid_o 1, rsp_data_o 4'b1011, rsp_empty_o 0, and fetch_cnt_o becomes 1.
- Fetch unprogrammed addr 7 -> rsp_data_o 0 and rsp_empty_o 1. After prog_clear_i, a refetch of addr 3 -> rsp_empty_o 1.
- Hold rsp_ready_i at 0 and fetch addrs 1, 2, 3 back-to-back -> only 1 and 2 are accepted and fetch_ready_o goes 0. Release rsp_ready_i -> responses arrive in order 1, 2, then 3 is accepted.
- Same-cycle write 4'b0110 and fetch to addr 5 (previously 4'b0001) -> the response is 4'b0001, and the next fetch of addr 5 returns 4'b0110.
- Perform 256 completed responses -> fetch_cnt_o wraps to 0. Assert rst_n low with 2 queued responses -> rsp_valid_o goes 0 immediately and the queue is empty after release.
